// File: rtl/band_scan.sv
// Pixel pass-through with a scan-row overlay; on the scan row, finds up to four colour bands
// that differ from the body colour and reports them once per frame.
module band_scan #(
    parameter int unsigned ROW     = 360,
    parameter int unsigned MIN_RUN = 8,
    parameter int unsigned OVERLAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_i,
    input  logic        vde_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [23:0] data_o,
    output logic        vde_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [23:0] bands_o,
    output logic [2:0]  band_cnt_o,
    output logic [5:0]  body_o,
    output logic        valid_o
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [7:0] MIN_L  = 8'(MIN_RUN);
    localparam logic [7:0] MIN_M1 = 8'(MIN_RUN - 1);

    state_t         state;
    logic [10:0]    x;
    logic [10:0]    y;
    logic           frame_ok;
    logic [5:0]     body_key;
    logic [5:0]     run_key;
    logic [5:0]     prev_q;
    logic [7:0]     run_len;
    logic [3:0][5:0] slot;
    logic [2:0]     cnt;

    logic [5:0] key;
    logic       on_row;
    logic       vs_rise;
    logic       vde_fall;

    // vde_o/vsync_o double as the one-cycle history for edge detection.
    assign key      = {data_i[23:22], data_i[7:6], data_i[15:14]};
    assign on_row   = ({21'd0, y} == ROW);
    assign vs_rise  = vsync_i && !vsync_o;
    assign vde_fall = !vde_i && vde_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            frame_ok   <= 1'b0;
            body_key   <= '0;
            run_key    <= '0;
            prev_q     <= '0;
            run_len    <= '0;
            slot       <= '0;
            cnt        <= '0;
            data_o     <= '0;
            vde_o      <= 1'b0;
            hsync_o    <= 1'b0;
            vsync_o    <= 1'b0;
            bands_o    <= '0;
            band_cnt_o <= '0;
            body_o     <= '0;
            valid_o    <= 1'b0;
        end else begin
            data_o  <= ((OVERLAY != 0) && vde_i && on_row) ? 24'hFF0000 : data_i;
            vde_o   <= vde_i;
            hsync_o <= hsync_i;
            vsync_o <= vsync_i;
            valid_o <= 1'b0;

            if (vde_i)
                x <= vde_o ? x + 11'd1 : 11'd0;

            if (vs_rise)
                y <= '0;
            else if (vde_fall && y != 11'h7FF)
                y <= y + 11'd1;

            if (vs_rise)
                frame_ok <= 1'b1;

            case (state)
                IDLE: begin
                    if (vde_i && on_row && frame_ok) begin
                        body_key <= key;
                        run_key  <= key;
                        prev_q   <= key;
                        run_len  <= 8'd1;
                        slot     <= '0;
                        cnt      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (vs_rise) begin
                        state <= IDLE;
                    end else if (vde_fall) begin
                        bands_o    <= slot;
                        band_cnt_o <= cnt;
                        body_o     <= body_key;
                        valid_o    <= 1'b1;
                        state      <= REPORT;
                    end else if (vde_i) begin
                        if (key == run_key) begin
                            if (run_len != MIN_L)
                                run_len <= run_len + 8'd1;
                            // Run reaches MIN_RUN on this pixel: qualifies exactly once.
                            if (run_len == MIN_M1) begin
                                prev_q <= key;
                                if (key != body_key && key != prev_q && cnt < 3'd4) begin
                                    slot[cnt[1:0]] <= key;
                                    cnt            <= cnt + 3'd1;
                                end
                            end
                        end else begin
                            run_key <= key;
                            run_len <= 8'd1;
                        end
                    end
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_band_scan.sv
// Bench for band_scan: randomized video frames checked against a run-length reference model.
module tb_band_scan;
    localparam int ROW  = 2;
    localparam int MINR = 4;
    localparam int LPX  = 32;

    logic        clk = 1'b0;
    logic        rst_n, vde, hs, vs;
    logic [23:0] din;

    logic [23:0] data_o, bands_o, f_data_o, f_bands_o;
    logic        vde_o, hsync_o, vsync_o, valid_o;
    logic        f_vde_o, f_hsync_o, f_vsync_o, f_valid_o;
    logic [2:0]  band_cnt_o, f_band_cnt_o;
    logic [5:0]  body_o, f_body_o;

    always #5 clk = ~clk;

    band_scan #(.ROW(ROW), .MIN_RUN(MINR), .OVERLAY(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(din), .vde_i(vde), .hsync_i(hs), .vsync_i(vs),
        .data_o(data_o), .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .bands_o(bands_o), .band_cnt_o(band_cnt_o), .body_o(body_o), .valid_o(valid_o));

    band_scan #(.ROW(100), .MIN_RUN(MINR), .OVERLAY(1)) dut_far (
        .clk(clk), .rst_n(rst_n), .data_i(din), .vde_i(vde), .hsync_i(hs), .vsync_i(vs),
        .data_o(f_data_o), .vde_o(f_vde_o), .hsync_o(f_hsync_o), .vsync_o(f_vsync_o),
        .bands_o(f_bands_o), .band_cnt_o(f_band_cnt_o), .body_o(f_body_o), .valid_o(f_valid_o));

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int          line = 0;
    bit          fok = 1'b0;
    bit          report_due = 1'b0;
    logic [5:0]  row_keys [LPX];
    logic [23:0] exp_bands, held_bands;
    logic [2:0]  exp_cnt, held_cnt;
    logic [5:0]  exp_body, held_body;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mkpix(input logic [5:0] k);
        logic [7:0] r, g, b;
        r = {k[5:4], 6'($urandom)};
        g = {k[3:2], 6'($urandom)};
        b = {k[1:0], 6'($urandom)};
        return {r, b, g};
    endfunction

    // Reference: split the row into maximal equal-key runs; long-enough runs qualify in order.
    task automatic model();
        logic [5:0] body, prev;
        int i, j, n;
        body = row_keys[0];
        prev = body;
        n = 0;
        exp_bands = '0;
        i = 0;
        while (i < LPX) begin
            j = i;
            while (j < LPX && row_keys[j] == row_keys[i]) j++;
            if (j - i >= MINR) begin
                if (row_keys[i] != body && row_keys[i] != prev && n < 4) begin
                    exp_bands[n*6 +: 6] = row_keys[i];
                    n++;
                end
                prev = row_keys[i];
            end
            i = j;
        end
        exp_cnt  = 3'(n);
        exp_body = body;
    endtask

    task automatic step();
        logic [23:0] ed, fd;
        logic ev, eh, evs, eval, r;
        r    = rst_n;
        ed   = (vde && line == ROW) ? 24'hFF0000 : din;
        fd   = din;
        ev   = vde;
        eh   = hs;
        evs  = vs;
        eval = report_due && !vde;
        @(posedge clk);
        #1;
        if (!r) begin
            ed = '0; fd = '0; ev = 0; eh = 0; evs = 0; eval = 0;
            report_due = 0;
            held_bands = '0; held_cnt = '0; held_body = '0;
            line = 0;
            fok  = 0;
        end else if (eval) begin
            held_bands = exp_bands; held_cnt = exp_cnt; held_body = exp_body;
            report_due = 0;
        end
        chk("vde_o", 32'(vde_o), 32'(ev));
        chk("hsync_o", 32'(hsync_o), 32'(eh));
        chk("vsync_o", 32'(vsync_o), 32'(evs));
        chk("data_o", 32'(data_o), 32'(ed));
        chk("valid_o", 32'(valid_o), 32'(eval));
        chk("bands_o", 32'(bands_o), 32'(held_bands));
        chk("band_cnt_o", 32'(band_cnt_o), 32'(held_cnt));
        chk("body_o", 32'(body_o), 32'(held_body));
        chk("far_data_o", 32'(f_data_o), 32'(fd));
        chk("far_valid_o", 32'(f_valid_o), 32'(0));
        chk("far_results", {f_body_o, f_band_cnt_o, f_bands_o[22:0]}, 32'(0));
    endtask

    task automatic blank(input int n, input bit vsy);
        for (int i = 0; i < n; i++) begin
            vde = 0; vs = vsy; hs = 1'($urandom); din = $urandom;
            step();
        end
    endtask

    task automatic vsync_frame();
        blank(3, 1);
        line = 0;
        fok  = 1;
        blank(2, 0);
    endtask

    // evt 0: plain line; 1: vsync pulse at pixel 'at'; 2: reset for two pixels from 'at'.
    task automatic active(input int at, input int evt);
        bit planned;
        planned = (line == ROW) && fok && (evt == 0);
        for (int i = 0; i < LPX; i++) begin
            vde   = 1; hs = 0;
            vs    = (evt == 1 && i == at);
            rst_n = !(evt == 2 && i >= at && i < at + 2);
            din   = mkpix(row_keys[i]);
            step();
            if (evt == 1 && i == at) line = 0;
        end
        rst_n = 1;
        vs    = 0;
        if (planned) begin
            model();
            report_due = 1;
        end
        line = (line < 2047) ? line + 1 : 2047;
        blank(4, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < LPX; i++) row_keys[i] = 6'($urandom);
    endtask

    task automatic fill_runs();
        logic [5:0] body, k;
        int i, len;
        body = 6'($urandom);
        row_keys[0] = body;
        i = 1;
        while (i < LPX) begin
            k   = ($urandom_range(0, 2) == 0) ? body : 6'($urandom);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len && i < LPX; j++) begin
                row_keys[i] = k;
                i++;
            end
        end
    endtask

    task automatic seg(input int start, input int len, input logic [5:0] k);
        for (int i = start; i < start + len; i++) row_keys[i] = k;
    endtask

    task automatic line_rand();
        fill_random();
        active(0, 0);
    endtask

    initial begin
        rst_n = 0; vde = 0; hs = 0; vs = 0; din = '0;
        held_bands = '0; held_cnt = '0; held_body = '0;
        exp_bands = '0; exp_cnt = '0; exp_body = '0;
        blank(3, 0);
        rst_n = 1;

        // No vsync yet: scan row passes by without a report.
        for (int l = 0; l < 4; l++) line_rand();

        // Basic bands.
        vsync_frame();
        line_rand(); line_rand();
        seg(0, LPX, 6'h2A);
        seg(4, 4, 6'h00); seg(12, 4, 6'h30); seg(20, 4, 6'h0C);
        active(0, 0);
        line_rand();
        chk("basic_bands", 32'(bands_o), 32'h00CC00);
        chk("basic_cnt", 32'(band_cnt_o), 32'd3);
        chk("basic_body", 32'(body_o), 32'h2A);

        // Short run ignored, glitch-split run recorded once.
        vsync_frame();
        line_rand(); line_rand();
        seg(0, LPX, 6'h15);
        seg(5, 3, 6'h30); seg(12, 4, 6'h0C); seg(20, 4, 6'h00);
        seg(24, 2, 6'h3F); seg(26, 4, 6'h00);
        active(0, 0);
        line_rand();
        chk("runs_bands", 32'(bands_o), 32'h00000C);
        chk("runs_cnt", 32'(band_cnt_o), 32'd2);

        // Six bands: only the first four kept.
        vsync_frame();
        line_rand(); line_rand();
        seg(0, LPX, 6'h2A);
        for (int b = 0; b < 6; b++) seg(2 + 4 * b, 4, 6'(b + 1));
        active(0, 0);
        line_rand();
        chk("many_bands", 32'(bands_o), 32'h103081);
        chk("many_cnt", 32'(band_cnt_o), 32'd4);

        // Randomized rows.
        for (int f = 0; f < 6; f++) begin
            vsync_frame();
            line_rand(); line_rand();
            fill_runs();
            active(0, 0);
            line_rand();
        end

        // vsync during the scan row aborts without a report.
        vsync_frame();
        line_rand(); line_rand();
        fill_runs();
        active(16, 1);

        // Reset mid scan row; scanning resumes only after the next vsync.
        vsync_frame();
        line_rand(); line_rand();
        fill_runs();
        active(10, 2);
        for (int l = 0; l < 4; l++) line_rand();
        vsync_frame();
        line_rand(); line_rand();
        fill_runs();
        active(0, 0);
        line_rand();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
